// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter
// Round-robin owner selection for a shared 16:1 mux. The one-hot grant,
// the binary mux select and the valid qualifier are all registered.
// Each owner may keep the mux for at most MAX_HOLD consecutive cycles
// while other requesters are waiting.
// Optional build macro ARB_PRIO0_EN: requester 0 wins every arbitration
// it takes part in, and the round-robin pointer is left alone when it does.
module mux16_rr_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   output logic [15:0] grant,
   output logic [3:0]  sel,
   output logic        valid,
   output logic        owner_switch
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);

   logic [0:0]       state, state_nxt;
   logic [3:0]       ptr, ptr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       sel_nxt;
   logic [15:0]      grant_nxt;
   logic             switch_nxt;

   logic             arb;
   logic [15:0]      arb_vec;
   logic [3:0]       arb_start;
   logic [3:0]       win;
   logic [15:0]      owner_bit;

   // First set bit of vec, scanning cyclically upward from start.
   // The scan runs backwards so the closest hit is the last one written.
   function automatic logic [3:0] find_first(input logic [15:0] vec,
                                             input logic [3:0]  start);
      logic [3:0] r;
      logic [3:0] idx;
      r = start;
      for (int k = 15; k >= 0; k--) begin
         idx = start + 4'(k);
         if (vec[idx]) r = idx;
      end
      return r;
   endfunction

   assign owner_bit = 16'd1 << sel;

   // Decide whether this cycle is an arbitration point, then pick the next owner.
   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      cnt_nxt    = cnt;
      sel_nxt    = sel;
      grant_nxt  = grant;
      switch_nxt = 1'b0;
      arb        = 1'b0;
      arb_vec    = '0;
      arb_start  = ptr;
      win        = '0;

      case (state)
         IDLE: begin
            grant_nxt = '0;
            if (|req) begin
               arb       = 1'b1;
               arb_vec   = req;
               arb_start = ptr;
            end
         end
         default: begin
            if (!req[sel]) begin
               if (|req) begin
                  arb       = 1'b1;
                  arb_vec   = req;
                  arb_start = sel + 4'd1;
               end else begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
                  cnt_nxt   = '0;
               end
            end else if (cnt == LAST_CNT) begin
               if (|(req & ~owner_bit)) begin
                  arb       = 1'b1;
                  arb_vec   = req & ~owner_bit;
                  arb_start = sel + 4'd1;
               end else begin
                  cnt_nxt = '0;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      endcase

      if (arb) begin
         win     = find_first(arb_vec, arb_start);
         ptr_nxt = win + 4'd1;
`ifdef ARB_PRIO0_EN
         if (arb_vec[0]) begin
            win     = 4'd0;
            ptr_nxt = ptr;
         end
`else
`endif
         state_nxt  = GRANT;
         cnt_nxt    = '0;
         sel_nxt    = win;
         grant_nxt  = 16'd1 << win;
         switch_nxt = 1'b1;
      end
   end

   // Register arbitration state and all outputs; reset clears them at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= '0;
         cnt          <= '0;
         sel          <= '0;
         grant        <= '0;
         valid        <= 1'b0;
         owner_switch <= 1'b0;
      end else begin
         state        <= state_nxt;
         ptr          <= ptr_nxt;
         cnt          <= cnt_nxt;
         sel          <= sel_nxt;
         grant        <= grant_nxt;
         valid        <= |grant_nxt;
         owner_switch <= switch_nxt;
      end
   end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter
// Directed and randomized stimulus for mux16_rr_arbiter, compared against
// a behavioural model that tracks the current owner as an integer.
module tb_mux16_rr_arbiter;

   localparam int HOLD = 8;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] grant;
   logic [3:0]  sel;
   logic        valid;
   logic        owner_switch;

   int n_vec;
   int n_err;

   // model state: owner -1 means nobody holds the mux
   int m_owner;
   int m_sel;
   int m_ptr;
   int m_held;
   bit m_switch;

   logic [15:0] r;

   mux16_rr_arbiter #(.MAX_HOLD(HOLD), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .sel         (sel),
      .valid       (valid),
      .owner_switch(owner_switch)
   );

   // free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void modelReset();
      m_owner  = -1;
      m_sel    = 0;
      m_ptr    = 0;
      m_held   = 0;
      m_switch = 1'b0;
   endfunction

   // One clock of the arbitration rules, applied to the sampled request vector.
   function automatic void modelStep(input logic [15:0] rq);
      logic [15:0] pool;
      int start;
      int cand;
      bit arbitrate;
      arbitrate = 1'b0;
      pool      = rq;
      start     = m_ptr;
      m_switch  = 1'b0;
      if (m_owner < 0) begin
         arbitrate = (rq != 16'h0);
      end else if (rq[m_owner] == 1'b0) begin
         start = (m_owner + 1) % 16;
         if (rq != 16'h0) arbitrate = 1'b1;
         else begin
            m_owner = -1;
            m_held  = 0;
         end
      end else if (m_held == HOLD - 1) begin
         pool[m_owner] = 1'b0;
         start = (m_owner + 1) % 16;
         if (pool != 16'h0) arbitrate = 1'b1;
         else m_held = 0;
      end else begin
         m_held = m_held + 1;
      end
      if (arbitrate) begin
         cand = -1;
         for (int k = 0; k < 16; k++)
            if (cand < 0 && pool[(start + k) % 16]) cand = (start + k) % 16;
`ifdef ARB_PRIO0_EN
         if (pool[0]) cand = 0;
         else m_ptr = (cand + 1) % 16;
`else
         m_ptr = (cand + 1) % 16;
`endif
         m_owner  = cand;
         m_sel    = cand;
         m_held   = 0;
         m_switch = 1'b1;
      end
   endfunction

   task automatic checkOutput(input string tag);
      logic [15:0] e_grant;
      logic [3:0]  e_sel;
      logic        e_valid;
      e_grant = (m_owner < 0) ? 16'h0 : (16'd1 << m_owner);
      e_sel   = 4'(m_sel);
      e_valid = (m_owner >= 0);
      n_vec++;
      assert (grant === e_grant) else begin
         n_err++;
         $error("[TB] FAIL %s grant observed=%h expected=%h", tag, grant, e_grant);
      end
      n_vec++;
      assert (valid === e_valid) else begin
         n_err++;
         $error("[TB] FAIL %s valid observed=%b expected=%b", tag, valid, e_valid);
      end
      n_vec++;
      assert (owner_switch === m_switch) else begin
         n_err++;
         $error("[TB] FAIL %s owner_switch observed=%b expected=%b", tag, owner_switch, m_switch);
      end
      n_vec++;
      assert (sel === e_sel) else begin
         n_err++;
         $error("[TB] FAIL %s sel observed=%h expected=%h", tag, sel, e_sel);
      end
   endtask

   // Drive req at a falling edge, let the DUT sample it, check at the next falling edge.
   task automatic applyStimulus(input logic [15:0] rq, input string tag);
      req = rq;
      @(posedge clk);
      modelStep(rq);
      @(negedge clk);
      checkOutput(tag);
   endtask

   task automatic resetDut(input logic [15:0] rq);
      @(negedge clk);
      rst_n = 1'b0;
      req   = rq;
      #2;
      modelReset();
      checkOutput("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      req   = 16'hFFFF;
      modelReset();
      r = 16'h0;

      // reset with everyone requesting, then first grant goes to 0
      resetDut(16'hFFFF);
      applyStimulus(16'hFFFF, "first_grant");
      applyStimulus(16'hFFFF, "all_hold");

      // single requester held past several quanta, then released
      resetDut(16'h0000);
      for (int i = 0; i < 20; i++) applyStimulus(16'h0020, "single");
      applyStimulus(16'h0000, "to_idle");
      applyStimulus(16'h0000, "idle_hold");

      // two-way contention from ptr=0 alternates 0 and 15 each quantum
      resetDut(16'h0000);
      for (int i = 0; i < 3 * HOLD + 2; i++) applyStimulus(16'h8001, "rotate");

      // early release hands off with no idle bubble
      resetDut(16'h0000);
      applyStimulus(16'h0008, "own3");
      applyStimulus(16'h0018, "own3_hold");
      applyStimulus(16'h0018, "own3_hold");
      applyStimulus(16'h0010, "handoff");
      applyStimulus(16'h0010, "handoff_hold");

      // drop and new arrival in the same cycle, wrap of ptr past 15
      applyStimulus(16'h8000, "drop_new");
      applyStimulus(16'h0001, "wrap");

      // asynchronous reset between edges
      resetDut(16'h0000);
      applyStimulus(16'h0080, "own7");
      applyStimulus(16'h0080, "own7_hold");
      @(posedge clk);
      modelStep(16'h0080);
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(16'hFF00, "restart");

`ifdef ARB_PRIO0_EN
      // requester 0 preempts at expiry, then yields one quantum to 1
      resetDut(16'h0000);
      applyStimulus(16'h0010, "own4");
      for (int i = 0; i < HOLD + 1; i++) applyStimulus(16'h0011, "prio_expiry");
      for (int i = 0; i < 3 * HOLD; i++) applyStimulus(16'h0003, "prio_yield");
`else
`endif

      // randomized request patterns, mostly held steady so quanta expire
      resetDut(16'h0000);
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(7))
            0: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            1: r = r | (16'd1 << $urandom_range(15));
            2: r = r & ~(16'd1 << $urandom_range(15));
            3: r = (i % 50 == 0) ? 16'h0 : r;
            default: r = r;
         endcase
         applyStimulus(r, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
